// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared pixel types, framebuffer defaults and write-FSM encoding
package gpu_pkg;

    typedef logic [23:0] color_t;
    typedef logic [7:0]  coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        color_t color;
    } pixel_t;

    localparam int FB_W_DEF       = 160;
    localparam int FB_H_DEF       = 120;
    localparam int ADDR_W_DEF     = 15;
    localparam int FIFO_DEPTH_DEF = 16;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_REQ  = 1'b1
    } wr_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - single-clock show-ahead FIFO for buffered pixels
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata    write request and data; ignored while full
//   pop, rdata     read request; rdata always shows the oldest entry
//   full, empty    occupancy flags
//   level          current number of entries (0..DEPTH)
module pixel_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (PW+1)'(DEPTH));
    assign empty   = (level == '0);
    // A pop in the same cycle never makes room for a push into a full FIFO.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (PW+1)'(1);
                2'b01:   level <= level - (PW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pixel_fb_writer.sv
// rtl/pixel_fb_writer.sv - clips rasteriser pixels, buffers them and writes them to the framebuffer
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_x/in_y/in_color    free-running pixel stream, no backpressure
//   in_done                        rasteriser done level; rising edge closes a shape
//   clr_overflow                   synchronous clear of the sticky overflow flag
//   mem_req/mem_addr/mem_wdata     framebuffer write request, held until mem_ack
//   mem_ack                        write accepted this cycle when mem_req is high
//   fifo_level                     pixel FIFO occupancy
//   overflow                       sticky: a pixel was dropped on a full FIFO
//   clip_cnt                       saturating count of out-of-bounds pixels
//   busy                           work buffered, in flight, or shape close pending
//   drained                        one-cycle pulse when a closed shape is fully written
module pixel_fb_writer
    import gpu_pkg::*;
#(
    parameter int FB_W       = FB_W_DEF,
    parameter int FB_H       = FB_H_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_x,
    input  logic [7:0]                    in_y,
    input  logic [23:0]                   in_color,
    input  logic                          in_done,
    input  logic                          clr_overflow,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [23:0]                   mem_wdata,
    input  logic                          mem_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   clip_cnt,
    output logic                          busy,
    output logic                          drained
);

    localparam logic [8:0] FB_W9 = 9'(FB_W);
    localparam logic [8:0] FB_H9 = 9'(FB_H);

    wr_state_t   state;
    pixel_t      in_pix;
    pixel_t      head_pix;
    logic        clipped;
    logic        push_req;
    logic        push;
    logic        drop;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        done_prev;
    logic        pending_done;
    logic [16:0] head_addr;

    assign in_pix   = '{x: in_x, y: in_y, color: in_color};
    assign clipped  = in_valid && (({1'b0, in_x} >= FB_W9) || ({1'b0, in_y} >= FB_H9));
    assign push_req = in_valid && !clipped;
    assign push     = push_req && !fifo_full;
    assign drop     = push_req && fifo_full;

    // Pop whenever the output register is free: idle, or its write is being accepted.
    assign pop = !fifo_empty && ((state == WR_IDLE) || mem_ack);

    // 255*256+255 fits in 17 bits for every legal FB_W.
    assign head_addr = 17'(head_pix.y) * 17'(FB_W) + 17'(head_pix.x);

    pixel_fifo #(
        .WIDTH ($bits(pixel_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_pix),
        .pop   (pop),
        .rdata (head_pix),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WR_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                WR_IDLE: begin
                    if (!fifo_empty) begin
                        mem_addr  <= ADDR_W'(head_addr);
                        mem_wdata <= head_pix.color;
                        mem_req   <= 1'b1;
                        state     <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (mem_ack) begin
                        if (!fifo_empty) begin
                            mem_addr  <= ADDR_W'(head_addr);
                            mem_wdata <= head_pix.color;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= WR_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            clip_cnt <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
            if (clipped && (clip_cnt != 16'hFFFF)) begin
                clip_cnt <= clip_cnt + 16'd1;
            end
        end
    end

    // A pixel arriving with the done edge is pushed at the same clock edge that
    // sets pending_done, so it is still counted as part of the closing shape.
    assign drained = pending_done && fifo_empty && (state == WR_IDLE) && !push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_prev    <= 1'b0;
            pending_done <= 1'b0;
        end else begin
            done_prev <= in_done;
            if (in_done && !done_prev) begin
                pending_done <= 1'b1;
            end else if (drained) begin
                pending_done <= 1'b0;
            end
        end
    end

    assign busy = !fifo_empty || mem_req || pending_done;

endmodule
